ps2_mouse_kempston: RTL and testbench

Converts the PS/2 mouse byte stream into Kempston mouse registers. Sits directly downstream of the PS/2 receiver, which runs in mouse mode (one strobe per byte, no E0/F0 handling), and drives the PS/2 host-to-device sender to enable streaming after reset. It assembles 3-byte movement packets, or 4-byte packets with the wheel build option. Outputs are X/Y position counters and a button byte read by the Spectrum I/O decoder on ports FBDF/FFDF/FADF.

---
 rtl/ps2_mouse_kempston.sv | 210 +++++++++++++++++++++
 tb/tb_ps2_mouse_kempston.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_kempston.sv
// Purpose: PS/2 mouse byte stream -> Kempston X/Y/button registers, with streaming-enable init.
// Latency: registers and packet_strobe update one cycle after the final packet byte's rx_strobe.
// Backpressure: none on rx (every strobe is consumed); tx waits on tx_busy and an FA acknowledge.
// Build option: define PS2_MOUSE_WHEEL_EN for IntelliMouse init and 4-byte wheel packets.
module ps2_mouse_kempston #(
  parameter logic [23:0] INIT_DELAY  = 24'd2800000,
  parameter logic [19:0] PKT_TIMEOUT = 20'd560000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_strobe,
  input  logic [7:0] rx_byte,
  output logic [7:0] tx_data,
  output logic       tx_load,
  input  logic       tx_busy,
  input  logic       tx_error,
  output logic [7:0] kmouse_x,
  output logic [7:0] kmouse_y,
  output logic [7:0] kmouse_buttons,
  output logic       packet_strobe,
  output logic       mouse_ready
);

`ifdef PS2_MOUSE_WHEEL_EN
  localparam logic [2:0] LAST_CMD = 3'd6;
  localparam logic [1:0] LAST_IDX = 2'd3;
`else
  localparam logic [2:0] LAST_CMD = 3'd0;
  localparam logic [1:0] LAST_IDX = 2'd2;
`endif

  typedef enum logic [2:0] {I_WAIT, I_SEND, I_TXWAIT, I_ACK, I_RUN} init_t;

  init_t       state, state_nx;
  logic [23:0] icnt, icnt_nx;
  logic [2:0]  k, k_nx;
  logic        tx_first, tx_first_nx;

`ifdef PS2_MOUSE_WHEEL_EN
  // IntelliMouse unlock: sample rates 200, 100, 80, then enable streaming.
  function automatic logic [7:0] cmd_byte(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd2, 3'd4: cmd_byte = 8'hF3;
      3'd1:             cmd_byte = 8'hC8;
      3'd3:             cmd_byte = 8'h64;
      3'd5:             cmd_byte = 8'h50;
      default:          cmd_byte = 8'hF4;
    endcase
  endfunction
`endif

  // Init FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= I_WAIT;
      icnt     <= 24'd0;
      k        <= 3'd0;
      tx_first <= 1'b0;
    end else begin
      state    <= state_nx;
      icnt     <= icnt_nx;
      k        <= k_nx;
      tx_first <= tx_first_nx;
    end
  end

  // Init FSM next state and command outputs.
  always_comb begin
    state_nx    = state;
    icnt_nx     = icnt;
    k_nx        = k;
    tx_first_nx = 1'b0;
    tx_load     = 1'b0;
    tx_data     = 8'h00;
    case (state)
      I_WAIT: begin
        if (icnt == INIT_DELAY - 24'd1) begin
          state_nx = I_SEND;
          icnt_nx  = 24'd0;
        end else begin
          icnt_nx = icnt + 24'd1;
        end
      end
      I_SEND: begin
        tx_load     = 1'b1;
`ifdef PS2_MOUSE_WHEEL_EN
        tx_data     = cmd_byte(k);
`else
        tx_data     = 8'hF4;
`endif
        tx_first_nx = 1'b1;
        state_nx    = I_TXWAIT;
      end
      I_TXWAIT: begin
        // The sender needs a cycle to raise busy, so the first cycle is not trusted.
        if (!tx_first && !tx_busy) begin
          icnt_nx = 24'd0;
          if (tx_error) begin
            state_nx = I_WAIT;
            k_nx     = 3'd0;
          end else begin
            state_nx = I_ACK;
          end
        end
      end
      I_ACK: begin
        if (rx_strobe && rx_byte == 8'hFA) begin
          icnt_nx = 24'd0;
          if (k == LAST_CMD) begin
            state_nx = I_RUN;
          end else begin
            k_nx     = k + 3'd1;
            state_nx = I_SEND;
          end
        end else if (icnt == {4'd0, PKT_TIMEOUT}) begin
          state_nx = I_WAIT;
          k_nx     = 3'd0;
          icnt_nx  = 24'd0;
        end else begin
          icnt_nx = icnt + 24'd1;
        end
      end
      I_RUN:   state_nx = I_RUN;
      default: state_nx = I_WAIT;
    endcase
  end

  assign mouse_ready = (state == I_RUN);

  logic [1:0]  idx;
  logic [19:0] pcnt;
  logic [2:0]  hdr_btn;   // {M, R, L} as received
  logic        hdr_xovf;
  logic        hdr_yovf;
  logic [7:0]  dx;
  logic [7:0]  dy_fin;
  logic [2:0]  btn_lo;
  logic [3:0]  wheel;

`ifdef PS2_MOUSE_WHEEL_EN
  logic [7:0] dy;
  assign dy_fin = dy;
`else
  assign dy_fin = rx_byte;
`endif

  assign kmouse_buttons = {wheel, 1'b1, btn_lo};

  // Packet assembly, inter-byte timeout and Kempston register update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx           <= 2'd0;
      pcnt          <= 20'd0;
      hdr_btn       <= 3'd0;
      hdr_xovf      <= 1'b0;
      hdr_yovf      <= 1'b0;
      dx            <= 8'h00;
`ifdef PS2_MOUSE_WHEEL_EN
      dy            <= 8'h00;
`endif
      kmouse_x      <= 8'h00;
      kmouse_y      <= 8'h00;
      btn_lo        <= 3'b111;
      wheel         <= 4'hF;
      packet_strobe <= 1'b0;
    end else begin
      packet_strobe <= 1'b0;
      if (state == I_RUN) begin
        if (rx_strobe) begin
          // A byte arriving on the expiry cycle wins over the timeout.
          pcnt <= 20'd0;
          if (idx == 2'd0) begin
            // Header must carry the always-one bit; anything else is dropped to resync.
            if (rx_byte[3]) begin
              hdr_btn  <= rx_byte[2:0];
              hdr_xovf <= rx_byte[6];
              hdr_yovf <= rx_byte[7];
              idx      <= 2'd1;
            end
          end else if (idx == LAST_IDX) begin
            if (!hdr_xovf) kmouse_x <= kmouse_x + dx;
            if (!hdr_yovf) kmouse_y <= kmouse_y + dy_fin;
            btn_lo        <= {~hdr_btn[2], ~hdr_btn[0], ~hdr_btn[1]};
`ifdef PS2_MOUSE_WHEEL_EN
            wheel         <= wheel + rx_byte[3:0];
`endif
            packet_strobe <= 1'b1;
            idx           <= 2'd0;
          end else begin
            if (idx == 2'd1) dx <= rx_byte;
`ifdef PS2_MOUSE_WHEEL_EN
            else dy <= rx_byte;
`endif
            idx <= idx + 2'd1;
          end
        end else if (idx != 2'd0) begin
          if (pcnt == PKT_TIMEOUT) begin
            idx  <= 2'd0;
            pcnt <= 20'd0;
          end else begin
            pcnt <= pcnt + 20'd1;
          end
        end else begin
          pcnt <= 20'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_kempston.sv
// Bench for ps2_mouse_kempston: scripted mouse/sender model plus a packet scoreboard.
// Expected register values come from a byte-list model of the packet rules.
// A negedge monitor pops one expectation per packet_strobe.
module tb_ps2_mouse_kempston;
  localparam logic [23:0] INIT_D = 24'd60;
  localparam logic [19:0] PKT_T  = 20'd40;
`ifdef PS2_MOUSE_WHEEL_EN
  localparam int NB = 4;
  localparam int NCMD = 7;
`else
  localparam int NB = 3;
  localparam int NCMD = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_strobe;
  logic [7:0] rx_byte;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_busy;
  logic       tx_error;
  logic [7:0] kmouse_x, kmouse_y, kmouse_buttons;
  logic       packet_strobe;
  logic       mouse_ready;

  ps2_mouse_kempston #(.INIT_DELAY(INIT_D), .PKT_TIMEOUT(PKT_T)) dut (
    .clk(clk), .rst_n(rst_n), .rx_strobe(rx_strobe), .rx_byte(rx_byte),
    .tx_data(tx_data), .tx_load(tx_load), .tx_busy(tx_busy), .tx_error(tx_error),
    .kmouse_x(kmouse_x), .kmouse_y(kmouse_y), .kmouse_buttons(kmouse_buttons),
    .packet_strobe(packet_strobe), .mouse_ready(mouse_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;
  int n_load = 0;

  typedef struct { logic [7:0] x; logic [7:0] y; logic [7:0] b; } exp_t;
  exp_t exp_q[$];

  // Reference model state.
  logic [7:0] pkt_q[$];
  logic [7:0] mx, my;
  logic [3:0] mw;
  logic [2:0] mlo;
  int         last_cyc;
  bit         run;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_cmd(input int j);
`ifdef PS2_MOUSE_WHEEL_EN
    case (j)
      0, 2, 4: exp_cmd = 8'hF3;
      1:       exp_cmd = 8'hC8;
      3:       exp_cmd = 8'h64;
      5:       exp_cmd = 8'h50;
      default: exp_cmd = 8'hF4;
    endcase
`else
    exp_cmd = (j == 0) ? 8'hF4 : 8'h00;
`endif
  endfunction

  task automatic model_reset();
    mx = 8'h00; my = 8'h00; mw = 4'hF; mlo = 3'b111;
    pkt_q.delete(); exp_q.delete();
    last_cyc = -100000; run = 0;
  endtask

  // Packet rules: bytes only count once streaming; a long gap discards a partial
  // packet; a header without bit3 is dropped; a full packet moves X/Y and sets buttons.
  task automatic model_byte(input logic [7:0] b, input int c);
    logic [7:0] h;
    logic [7:0] dz;
    exp_t e;
    if (!run) return;
    if (pkt_q.size() > 0 && (c - last_cyc - 1) > int'(PKT_T)) pkt_q.delete();
    last_cyc = c;
    if (pkt_q.size() == 0 && !b[3]) return;
    pkt_q.push_back(b);
    if (pkt_q.size() == NB) begin
      h = pkt_q[0];
      if (!h[6]) mx = mx + pkt_q[1];
      if (!h[7]) my = my + pkt_q[2];
      mlo = {~h[2], ~h[0], ~h[1]};
      if (NB == 4) begin
        dz = pkt_q[NB-1];
        mw = mw + dz[3:0];
      end
      e.x = mx; e.y = my; e.b = {mw, 1'b1, mlo};
      exp_q.push_back(e);
      pkt_q.delete();
    end
  endtask

  // Idle for the given number of sampled cycles, then one rx_strobe cycle.
  task automatic send(input logic [7:0] b, input int idle);
    repeat (idle) @(posedge clk);
    #1 rx_strobe = 1'b1; rx_byte = b;
    @(posedge clk);
    #1 rx_strobe = 1'b0;
    model_byte(b, cyc);
  endtask

  // mode 0: all commands acknowledged; 1: sender error on first; 2: no FA on first.
  task automatic init_attempt(input int mode);
    bit found;
    for (int j = 0; j < NCMD; j++) begin
      found = 0;
      for (int i = 0; i < 3000 && !found; i++) begin
        @(negedge clk);
        if (tx_load) found = 1;
      end
      if (!found) begin
        compared++; mismatched++;
        $display("FAIL init_tx_wait: no tx_load for command %0d (mode %0d)", j, mode);
        @(posedge clk); #1;
        return;
      end
      check("tx_data", tx_data, exp_cmd(j));
      @(posedge clk); #1 tx_busy = 1'b1;
      @(negedge clk); check("tx_load_pulse", tx_load, 0);
      repeat (4) @(posedge clk);
      #1 tx_busy = 1'b0; tx_error = (mode == 1);
      @(posedge clk); #1 tx_error = 1'b0;
      if (mode == 1) begin
        check("ready_after_txerr", mouse_ready, 0);
        return;
      end
      if (mode == 2) begin
        send(8'hFE, 2);
        repeat (int'(PKT_T)) @(posedge clk);
        #1 check("ready_after_noack", mouse_ready, 0);
        return;
      end
      send(8'h3C, 1);
      check("ready_before_fa", mouse_ready, 0);
      send(8'hFA, 2);
    end
    @(negedge clk); check("mouse_ready", mouse_ready, 1);
    @(posedge clk); #1 run = 1;
  endtask

  task automatic drain_and_check(input string tag);
    repeat (5) @(posedge clk);
    #1;
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    check({tag, "_x"}, kmouse_x, mx);
    check({tag, "_y"}, kmouse_y, my);
    check({tag, "_buttons"}, kmouse_buttons, {mw, 1'b1, mlo});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_x"}, kmouse_x, 8'h00);
    check({tag, "_y"}, kmouse_y, 8'h00);
    check({tag, "_buttons"}, kmouse_buttons, 8'hFF);
    check({tag, "_tx_data"}, tx_data, 8'h00);
    check({tag, "_tx_load"}, tx_load, 0);
    check({tag, "_strobe"}, packet_strobe, 0);
    check({tag, "_ready"}, mouse_ready, 0);
  endtask

  // Scoreboard monitor: every packet_strobe consumes one expectation.
  always @(negedge clk) begin
    if (rst_n && packet_strobe) begin
      if (exp_q.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL unexpected_strobe: got strobe expected none (t=%0t)", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pkt_x", kmouse_x, e.x);
        check("pkt_y", kmouse_y, e.y);
        check("pkt_buttons", kmouse_buttons, e.b);
      end
    end
    if (rst_n && tx_load) n_load++;
  end

  initial begin
    int n0;
    int idle;
    logic [7:0] b;
    rst_n = 1'b0; rx_strobe = 1'b0; rx_byte = 8'h00; tx_busy = 1'b0; tx_error = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    rst_n = 1'b1;

    n0 = n_load;
    init_attempt(1);
    init_attempt(2);
    init_attempt(0);
    repeat (100) @(posedge clk);
    #1 check("tx_load_count", n_load - n0, 2 + NCMD);

    // Directed packets.
    send(8'h08, 1); send(8'h05, 0); send(8'h03, 0);
    send(8'h19, 2); send(8'hFB, 0); send(8'hFE, 1);
    send(8'h00, 3); send(8'h48, 0); send(8'h10, 0); send(8'h20, 0);
    drain_and_check("directed");
    send(8'h08, 1); send(8'h05, 0); send(8'h08, int'(PKT_T) + 1);
    send(8'h01, 0); send(8'h01, 0);
    send(8'h08, 2); send(8'h02, 0); send(8'h03, int'(PKT_T));
    drain_and_check("timeout");

    // Random byte stream with gaps straddling the timeout.
    for (int i = 0; i < 120; i++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 9) < 7) idle = $urandom_range(0, 3);
      else idle = $urandom_range(int'(PKT_T) - 1, int'(PKT_T) + 2);
      send(b, idle);
    end
    drain_and_check("random");

    // Reset mid-packet, then a fresh init and packet from zero.
    send(8'h08, 1); send(8'h05, 0);
    @(posedge clk); #1 rst_n = 1'b0;
    #2 check_reset_outputs("midreset");
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    init_attempt(0);
    send(8'h08, 1); send(8'h01, 0); send(8'h01, 0);
    if (NB == 4) send(8'h0F, 0);
    drain_and_check("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
